hazard_ctrl: RTL and testbench

// - Pipeline hazard controller for the 5-stage Osiris I core; sequences the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// - Generates EX operand forwarding selects, load-use stalls, branch/jump flushes and data-memory wait-state freezes.
// - Runs a timeout FSM for memory waits. Counts stall cycles in a saturating counter for performance monitoring.
// - o_flush_EX drives the ID/EX register clear input.

---
 rtl/osiris_pkg.sv | 23 ++
 rtl/fwd_unit.sv | 44 ++++
 rtl/hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osiris_pkg.sv
// -----------------------------------------------------------------------------
// osiris_pkg
// Shared definitions for the Osiris I pipeline hazard controller.
//   RESULT_SRC_LOAD : result-source encoding that marks a load in EX
//   FWD_*           : EX operand forwarding select encodings
//   hz_state_t      : memory-wait supervision FSM states
// -----------------------------------------------------------------------------
package osiris_pkg;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // Operand select driven into the EX-stage operand muxes.
    localparam logic [1:0] FWD_REG = 2'b00;  // value read from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // value from MEM/WB register
    localparam logic [1:0] FWD_MEM = 2'b10;  // value from EX/MEM register

    typedef enum logic [1:0] {
        RUN   = 2'b00,  // normal flow, no memory wait outstanding
        WAIT  = 2'b01,  // data memory has been stalling the pipe
        ERROR = 2'b10   // memory timed out; pipe frozen until reset
    } hz_state_t;

endpackage : osiris_pkg

// File: rtl/fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Combinational forwarding select for one EX-stage source operand.
// Ports:
//   rs_addr_EX      in  source register address of the operand in EX
//   rd_MEM          in  destination register of the instruction in MEM
//   reg_write_MEM   in  MEM instruction writes the register file
//   rd_WB           in  destination register of the instruction in WB
//   reg_write_WB    in  WB instruction writes the register file
//   fwd_sel         out operand select (FWD_REG / FWD_MEM / FWD_WB)
// -----------------------------------------------------------------------------
module fwd_unit
    import osiris_pkg::*;
#(
    parameter int REG_WIDTH = 4
) (
    input  logic [REG_WIDTH-1:0] rs_addr_EX,
    input  logic [REG_WIDTH-1:0] rd_MEM,
    input  logic                 reg_write_MEM,
    input  logic [REG_WIDTH-1:0] rd_WB,
    input  logic                 reg_write_WB,
    output logic [1:0]           fwd_sel
);

    logic hit_mem;
    logic hit_wb;

    // x0 is hard-wired to zero, so a write to it must never be forwarded.
    assign hit_mem = reg_write_MEM && (rd_MEM != '0) && (rd_MEM == rs_addr_EX);
    assign hit_wb  = reg_write_WB  && (rd_WB  != '0) && (rd_WB  == rs_addr_EX);

    // MEM holds the younger result, so it wins when both stages match.
    always_comb begin
        // NOTE: combinational blocks assign a default first so every path
        // drives the output and no latch is inferred.
        fwd_sel = FWD_REG;
        if (hit_mem) begin
            fwd_sel = FWD_MEM;
        end else if (hit_wb) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule : fwd_unit

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage Osiris I core. Produces EX operand
// forwarding selects, load-use stalls, branch/jump flushes and data-memory
// freezes, supervises memory waits with a timeout FSM and counts stalled cycles.
// Ports:
//   clk, rst                       core clock, asynchronous active-high reset
//   i_rs1Addr_ID / i_rs2Addr_ID    source registers of the instruction in ID
//   i_rs1Addr_EX / i_rs2Addr_EX    source registers of the instruction in EX
//   i_rd_EX, i_result_src_EX       destination and result source in EX
//   i_pc_src_EX                    branch taken / jump resolved in EX
//   i_rd_MEM, i_reg_write_MEM      destination and write enable in MEM
//   i_rd_WB,  i_reg_write_WB       destination and write enable in WB
//   i_mem_req_MEM, i_mem_ready     data-memory request and handshake
//   o_forward_a_EX/o_forward_b_EX  operand selects (00 regfile, 10 MEM, 01 WB)
//   o_stall_IF/ID/EX/MEM           hold PC / IF/ID / ID/EX / EX/MEM+MEM/WB
//   o_flush_ID / o_flush_EX        clear IF/ID / ID/EX registers
//   o_mem_err                      sticky memory timeout error
//   o_stall_cycles                 saturating count of cycles with PC held
// -----------------------------------------------------------------------------
module hazard_ctrl
    import osiris_pkg::*;
#(
    parameter int REG_WIDTH = 4,
    parameter int MAX_WAIT  = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] i_rs1Addr_ID,
    input  logic [REG_WIDTH-1:0] i_rs2Addr_ID,
    input  logic [REG_WIDTH-1:0] i_rs1Addr_EX,
    input  logic [REG_WIDTH-1:0] i_rs2Addr_EX,
    input  logic [REG_WIDTH-1:0] i_rd_EX,
    input  logic [1:0]           i_result_src_EX,
    input  logic                 i_pc_src_EX,
    input  logic [REG_WIDTH-1:0] i_rd_MEM,
    input  logic                 i_reg_write_MEM,
    input  logic [REG_WIDTH-1:0] i_rd_WB,
    input  logic                 i_reg_write_WB,
    input  logic                 i_mem_req_MEM,
    input  logic                 i_mem_ready,
    output logic [1:0]           o_forward_a_EX,
    output logic [1:0]           o_forward_b_EX,
    output logic                 o_stall_IF,
    output logic                 o_stall_ID,
    output logic                 o_stall_EX,
    output logic                 o_stall_MEM,
    output logic                 o_flush_ID,
    output logic                 o_flush_EX,
    output logic                 o_mem_err,
    output logic [CNT_WIDTH-1:0] o_stall_cycles
);

    // Wide enough to hold MAX_WAIT itself.
    localparam int WCW = $clog2(MAX_WAIT + 1);

    hz_state_t      state, state_nxt;
    logic [WCW-1:0] wait_cnt, wait_cnt_nxt;

    logic mw;  // data memory is holding the MEM stage this cycle
    logic lu;  // load in EX feeds a source operand of the instruction in ID

    // -------------------------------------------------------------------------
    // Operand forwarding
    // -------------------------------------------------------------------------
    fwd_unit #(.REG_WIDTH(REG_WIDTH)) u_fwd_a (
        .rs_addr_EX    (i_rs1Addr_EX),
        .rd_MEM        (i_rd_MEM),
        .reg_write_MEM (i_reg_write_MEM),
        .rd_WB         (i_rd_WB),
        .reg_write_WB  (i_reg_write_WB),
        .fwd_sel       (o_forward_a_EX)
    );

    fwd_unit #(.REG_WIDTH(REG_WIDTH)) u_fwd_b (
        .rs_addr_EX    (i_rs2Addr_EX),
        .rd_MEM        (i_rd_MEM),
        .reg_write_MEM (i_reg_write_MEM),
        .rd_WB         (i_rd_WB),
        .reg_write_WB  (i_reg_write_WB),
        .fwd_sel       (o_forward_b_EX)
    );

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    assign mw = i_mem_req_MEM && !i_mem_ready;

    assign lu = (i_result_src_EX == RESULT_SRC_LOAD) && (i_rd_EX != '0) &&
                ((i_rd_EX == i_rs1Addr_ID) || (i_rd_EX == i_rs2Addr_ID));

    // -------------------------------------------------------------------------
    // State register, wait counter and stall-cycle counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            wait_cnt       <= '0;
            o_stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            // Performance counter sticks at all-ones rather than wrapping.
            if (o_stall_IF && (o_stall_cycles != '1)) begin
                o_stall_cycles <= o_stall_cycles + CNT_WIDTH'(1);
            end
        end
    end

    assign o_mem_err = (state == ERROR);

    // -------------------------------------------------------------------------
    // Next state and pipeline control
    // Priority: ERROR > memory freeze > branch flush > load-use bubble.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        o_stall_IF   = 1'b0;
        o_stall_ID   = 1'b0;
        o_stall_EX   = 1'b0;
        o_stall_MEM  = 1'b0;
        o_flush_ID   = 1'b0;
        o_flush_EX   = 1'b0;

        // The first waiting cycle is already frozen combinationally while in
        // RUN, so the count reaches MAX_WAIT on the MAX_WAIT+1-th wait cycle.
        unique case (state)
            RUN: begin
                if (mw) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WCW'(1);
                end
            end
            WAIT: begin
                if (!mw) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WCW'(MAX_WAIT)) begin
                    state_nxt = ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase

        if (state == ERROR || mw) begin
            // Freeze the whole pipe. A resolved branch is held in EX and
            // performs its flush once the freeze lifts.
            o_stall_IF  = 1'b1;
            o_stall_ID  = 1'b1;
            o_stall_EX  = 1'b1;
            o_stall_MEM = 1'b1;
        end else if (i_pc_src_EX) begin
            // Wrong-path instructions in IF/ID and ID/EX are discarded; this
            // also removes any load-use consumer, so no bubble is needed.
            o_flush_ID = 1'b1;
            o_flush_EX = 1'b1;
        end else if (lu) begin
            // Hold the consumer in ID and inject one bubble into EX.
            o_stall_IF = 1'b1;
            o_stall_ID = 1'b1;
            o_flush_EX = 1'b1;
        end
    end

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl (MAX_WAIT=16, CNT_WIDTH=4). Inputs are
// driven on the falling edge, the expected control word is pushed to a
// scoreboard queue at the same time and popped/compared 2 time units later,
// well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int RW = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       s_if;
        logic       s_id;
        logic       s_ex;
        logic       s_mem;
        logic       f_id;
        logic       f_ex;
        logic       err;
    } ctl_t;

    logic          clk;
    logic          rst;
    logic [RW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic [1:0]    result_src;
    logic          pc_src, wr_mem, wr_wb, mem_req, mem_ready;
    logic [1:0]    fwd_a, fwd_b;
    logic          stall_if, stall_id, stall_ex, stall_mem;
    logic          flush_id, flush_ex, mem_err;
    logic [CW-1:0] stall_cycles;

    int   n_checks = 0;
    int   n_errors = 0;
    ctl_t exp_q[$];

    hazard_ctrl #(.REG_WIDTH(RW), .MAX_WAIT(16), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_rs1Addr_ID    (rs1_id),
        .i_rs2Addr_ID    (rs2_id),
        .i_rs1Addr_EX    (rs1_ex),
        .i_rs2Addr_EX    (rs2_ex),
        .i_rd_EX         (rd_ex),
        .i_result_src_EX (result_src),
        .i_pc_src_EX     (pc_src),
        .i_rd_MEM        (rd_mem),
        .i_reg_write_MEM (wr_mem),
        .i_rd_WB         (rd_wb),
        .i_reg_write_WB  (wr_wb),
        .i_mem_req_MEM   (mem_req),
        .i_mem_ready     (mem_ready),
        .o_forward_a_EX  (fwd_a),
        .o_forward_b_EX  (fwd_b),
        .o_stall_IF      (stall_if),
        .o_stall_ID      (stall_id),
        .o_stall_EX      (stall_ex),
        .o_stall_MEM     (stall_mem),
        .o_flush_ID      (flush_id),
        .o_flush_EX      (flush_ex),
        .o_mem_err       (mem_err),
        .o_stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t mk(input logic [1:0] fa, input logic [1:0] fb,
                                input logic s_if, input logic s_id,
                                input logic s_ex, input logic s_mem,
                                input logic f_id, input logic f_ex,
                                input logic err);
        ctl_t c;
        c = '{fa, fb, s_if, s_id, s_ex, s_mem, f_id, f_ex, err};
        return c;
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c = '{fwd_a, fwd_b, stall_if, stall_id, stall_ex, stall_mem,
              flush_id, flush_ex, mem_err};
        return c;
    endfunction

    // Expected control words for the non-forwarding scenarios.
    localparam ctl_t C_NONE = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctl_t C_LU   = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam ctl_t C_BR   = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam ctl_t C_FRZ  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam ctl_t C_ERR  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic clear_inputs();
        rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0;
        rd_ex = '0; rd_mem = '0; rd_wb = '0; result_src = 2'b00;
        pc_src = 1'b0; wr_mem = 1'b0; wr_wb = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        ctl_t e, a;
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        exp_q.push_back(C_NONE);
        #2;
        e = exp_q.pop_front(); a = observe(); n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL reset_ctl: got %b expected %b", a, e);
        end
        n_checks++;
        if (stall_cycles !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_cnt: got %0d expected 0", stall_cycles);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    typedef struct {
        logic [3:0] rs1, rs2, rdm, rdw;
        logic       wm, ww;
        logic [1:0] fa, fb;
    } fwd_row_t;

    task automatic test_forward();
        fwd_row_t rows[6];
        ctl_t e, a;
        rows[0] = '{4'd5,  4'd7,  4'd5,  4'd5,  1'b1, 1'b1, 2'b10, 2'b00};
        rows[1] = '{4'd5,  4'd7,  4'd5,  4'd5,  1'b0, 1'b1, 2'b01, 2'b00};
        rows[2] = '{4'd0,  4'd0,  4'd0,  4'd0,  1'b1, 1'b1, 2'b00, 2'b00};
        rows[3] = '{4'd5,  4'd9,  4'd9,  4'd5,  1'b1, 1'b1, 2'b01, 2'b10};
        rows[4] = '{4'd3,  4'd3,  4'd4,  4'd3,  1'b1, 1'b0, 2'b00, 2'b00};
        rows[5] = '{4'd12, 4'd12, 4'd12, 4'd12, 1'b1, 1'b1, 2'b10, 2'b10};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rs1_ex = rows[i].rs1; rs2_ex = rows[i].rs2;
            rd_mem = rows[i].rdm; wr_mem = rows[i].wm;
            rd_wb  = rows[i].rdw; wr_wb  = rows[i].ww;
            exp_q.push_back(mk(rows[i].fa, rows[i].fb, 0, 0, 0, 0, 0, 0, 0));
            #2;
            e = exp_q.pop_front(); a = observe(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL forward_row%0d: got %b expected %b", i, a, e);
            end
        end
        clear_inputs();
    endtask

    // ---------------------------------------------------------------------
    typedef struct {
        logic [1:0] src;
        logic [3:0] rd, rs1, rs2;
        logic       lu;
    } lu_row_t;

    task automatic test_load_use();
        lu_row_t rows[5];
        ctl_t e, a;
        do_reset();
        rows[0] = '{2'b01, 4'd3, 4'd1, 4'd3, 1'b1};  // rs2 hit
        rows[1] = '{2'b00, 4'd0, 4'd1, 4'd3, 1'b0};  // bubble now in EX
        rows[2] = '{2'b01, 4'd4, 4'd4, 4'd0, 1'b1};  // rs1 hit
        rows[3] = '{2'b01, 4'd0, 4'd0, 4'd0, 1'b0};  // load to x0
        rows[4] = '{2'b10, 4'd6, 4'd6, 4'd6, 1'b0};  // not a load
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            result_src = rows[i].src; rd_ex = rows[i].rd;
            rs1_id = rows[i].rs1; rs2_id = rows[i].rs2;
            exp_q.push_back(rows[i].lu ? C_LU : C_NONE);
            #2;
            e = exp_q.pop_front(); a = observe(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL load_use_row%0d: got %b expected %b", i, a, e);
            end
        end
        @(negedge clk);
        clear_inputs();
        #2;
        n_checks++;
        if (stall_cycles !== 4'd2) begin
            n_errors++;
            $display("FAIL load_use_cnt: got %0d expected 2", stall_cycles);
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_branch_lu();
        ctl_t e, a;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            result_src = (i == 0) ? 2'b01 : 2'b00;
            rd_ex = 4'd3; rs2_id = 4'd3; pc_src = 1'b1;
            exp_q.push_back(C_BR);
            #2;
            e = exp_q.pop_front(); a = observe(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL branch_cycle%0d: got %b expected %b", i, a, e);
            end
        end
        @(negedge clk);
        clear_inputs();
        #2;
        n_checks++;
        if (stall_cycles !== 4'd0) begin
            n_errors++;
            $display("FAIL branch_cnt: got %0d expected 0", stall_cycles);
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_mem_wait();
        ctl_t e, a;
        do_reset();
        // 3 wait cycles with a resolved branch in EX, then ready, then idle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pc_src    = (i < 4);
            mem_req   = (i < 4);
            mem_ready = (i == 3);
            exp_q.push_back((i < 3) ? C_FRZ : (i == 3) ? C_BR : C_NONE);
            #2;
            e = exp_q.pop_front(); a = observe(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL mem_wait_cycle%0d: got %b expected %b", i, a, e);
            end
        end
        n_checks++;
        if (stall_cycles !== 4'd3) begin
            n_errors++;
            $display("FAIL mem_wait_cnt: got %0d expected 3", stall_cycles);
        end
        // 16 wait cycles is one short of the timeout.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            mem_req   = (i < 17);
            mem_ready = (i >= 16);
            exp_q.push_back((i < 16) ? C_FRZ : C_NONE);
            #2;
            e = exp_q.pop_front(); a = observe(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL wait16_cycle%0d: got %b expected %b", i, a, e);
            end
        end
        clear_inputs();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_timeout();
        ctl_t e, a;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_req   = (i < 19);
            mem_ready = (i >= 17);
            pc_src    = (i >= 17);
            exp_q.push_back((i < 17) ? C_FRZ : C_ERR);
            #2;
            e = exp_q.pop_front(); a = observe(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL timeout_cycle%0d: got %b expected %b", i, a, e);
            end
        end
        // Asynchronous reset clears the error without waiting for an edge.
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_err !== 1'b0 || stall_cycles !== 4'd0) begin
            n_errors++;
            $display("FAIL timeout_rst: got err=%b cnt=%0d expected err=0 cnt=0",
                     mem_err, stall_cycles);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(C_NONE);
        #2;
        e = exp_q.pop_front(); a = observe(); n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL timeout_after_rst: got %b expected %b", a, e);
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_counter();
        ctl_t e, a;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (i < 20) begin
                result_src = 2'b01; rd_ex = 4'd7; rs1_id = 4'd7;
                exp_q.push_back(C_LU);
            end else begin
                clear_inputs();
                exp_q.push_back(C_NONE);
            end
            #2;
            e = exp_q.pop_front(); a = observe(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL counter_cycle%0d: got %b expected %b", i, a, e);
            end
            if (i == 10) begin
                n_checks++;
                if (stall_cycles !== 4'd10) begin
                    n_errors++;
                    $display("FAIL counter_mid: got %0d expected 10", stall_cycles);
                end
            end
        end
        n_checks++;
        if (stall_cycles !== 4'd15) begin
            n_errors++;
            $display("FAIL counter_sat: got %0d expected 15", stall_cycles);
        end
        // Reset in the middle of a memory wait.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_req = 1'b1; mem_ready = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(C_FRZ);
        #1;
        e = exp_q.pop_front(); a = observe(); n_checks++;
        if (a !== e || stall_cycles !== 4'd0) begin
            n_errors++;
            $display("FAIL counter_rst_wait: got %b cnt=%0d expected %b cnt=0",
                     a, stall_cycles, e);
        end
        // Back in RUN with a cleared wait count: 16 more waits must not time out.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst       = 1'b0;
            mem_req   = 1'b1;
            mem_ready = (i >= 16);
            exp_q.push_back((i < 16) ? C_FRZ : C_NONE);
            #2;
            e = exp_q.pop_front(); a = observe(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL rst_wait_cycle%0d: got %b expected %b", i, a, e);
            end
        end
        clear_inputs();
    endtask

    // ---------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_counter();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_hazard_ctrl
